cache_fill_arbiter: RTL

Memory-side controller that shares the single multicycle main memory between the instruction-fetch cache (I-side) and the data cache (D-side). It arbitrates I-miss fills, D-miss fills and D-side write-through stores, and sequences each fill as a burst of word reads. Each returned word is steered into the owning cache's data array, followed by a tag write. It sits between the fetch/memory pipeline stages' caches and the memory model, and drives no pipeline registers directly.

---
 rtl/cache_fill_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cache_fill_arbiter.sv
// Shares one multicycle main memory between I-cache fills, D-cache fills and D-side
// write-through stores; each fill is a burst of word reads steered into the owning cache.
module cache_fill_arbiter #(
  parameter int unsigned BLOCK_WORDS = 8,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ic_miss,
  input  logic [ADDR_W-1:0]              ic_miss_addr,
  input  logic                           dc_miss,
  input  logic [ADDR_W-1:0]              dc_miss_addr,
  input  logic                           dc_wr_req,
  input  logic [ADDR_W-1:0]              dc_wr_addr,
  input  logic [15:0]                    dc_wr_data,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [15:0]                    mem_data_in,
  output logic                           mem_enable,
  output logic                           mem_wr,
  input  logic [15:0]                    mem_data_out,
  input  logic                           mem_data_valid,
  output logic                           fill_sel,
  output logic                           fill_data_we,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic [15:0]                    fill_data,
  output logic                           fill_tag_we,
  output logic [ADDR_W-1:0]              fill_addr,
  output logic                           ic_fill_done,
  output logic                           dc_fill_done,
  output logic                           dc_wr_ack
);

  localparam int unsigned WordW = $clog2(BLOCK_WORDS);
  localparam logic [WordW:0]    NumWords = (WordW + 1)'(BLOCK_WORDS);
  localparam logic [WordW-1:0]  LastWord = WordW'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0] OffMask  = ADDR_W'(2 * BLOCK_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StFill} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic              fill_sel_q, fill_sel_d;
  // Issue counter is one bit wider so it can sit at BLOCK_WORDS once the burst is out.
  logic [WordW:0]    iss_q, iss_d;
  logic [WordW-1:0]  ret_q, ret_d;
  logic              issuing;
  logic              last_word;

  assign issuing   = (state_q == StFill) && (iss_q < NumWords);
  assign last_word = (state_q == StFill) && mem_data_valid && (ret_q == LastWord);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      fill_addr_q <= '0;
      fill_sel_q  <= 1'b0;
      iss_q       <= '0;
      ret_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      fill_addr_q <= fill_addr_d;
      fill_sel_q  <= fill_sel_d;
      iss_q       <= iss_d;
      ret_q       <= ret_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    fill_addr_d = fill_addr_q;
    fill_sel_d  = fill_sel_q;
    iss_d       = iss_q;
    ret_d       = ret_q;
    unique case (state_q)
      StIdle: begin
        // D-side requests belong to the older instruction, so they win.
        if (dc_wr_req) begin
          state_d   = StWrite;
          wr_addr_d = dc_wr_addr;
          wr_data_d = dc_wr_data;
        end else if (dc_miss) begin
          state_d     = StFill;
          fill_sel_d  = 1'b1;
          fill_addr_d = dc_miss_addr & ~OffMask;
          iss_d       = '0;
          ret_d       = '0;
        end else if (ic_miss) begin
          state_d     = StFill;
          fill_sel_d  = 1'b0;
          fill_addr_d = ic_miss_addr & ~OffMask;
          iss_d       = '0;
          ret_d       = '0;
        end
      end
      StWrite: state_d = StIdle;
      StFill: begin
        if (issuing) begin
          iss_d = iss_q + (WordW + 1)'(1);
        end
        if (mem_data_valid) begin
          ret_d = ret_q + WordW'(1);
        end
        if (last_word) begin
          state_d = StIdle;
          iss_d   = '0;
          ret_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    fill_data_we = 1'b0;
    fill_word    = '0;
    fill_data    = '0;
    fill_tag_we  = 1'b0;
    ic_fill_done = 1'b0;
    dc_fill_done = 1'b0;
    dc_wr_ack    = 1'b0;
    unique case (state_q)
      StWrite: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = wr_addr_q;
        mem_data_in = wr_data_q;
        dc_wr_ack   = 1'b1;
      end
      StFill: begin
        if (issuing) begin
          mem_enable = 1'b1;
          mem_addr   = fill_addr_q + ADDR_W'({iss_q, 1'b0});
        end
        // Completion counts returned words only; memory latency is not tracked.
        if (mem_data_valid) begin
          fill_data_we = 1'b1;
          fill_word    = ret_q;
          fill_data    = mem_data_out;
        end
        if (last_word) begin
          fill_tag_we  = 1'b1;
          ic_fill_done = ~fill_sel_q;
          dc_fill_done = fill_sel_q;
        end
      end
      default: ;
    endcase
  end

  assign fill_sel  = fill_sel_q;
  assign fill_addr = fill_addr_q;

endmodule
